// File: rtl/pmm_feeder.sv
// Host-side word FIFO and valid/ready transmitter for one PMM lane, capturing the per-sequence accept result.
// Optional watchdog abort is built when PMM_FEEDER_TIMEOUT_EN is defined.
module pmm_feeder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [63:0]                   in_data,
  input  logic [15:0]                   in_control,
  input  logic                          in_last,
  output logic [63:0]                   pmm_data,
  output logic [15:0]                   pmm_control,
  output logic                          pmm_data_valid,
  input  logic                          pmm_ready_status,
  input  logic                          pmm_accepted_status,
  output logic                          res_valid,
  output logic                          res_accepted,
  output logic                          res_timeout,
  output logic [CNT_W-1:0]              match_count,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [63:0] data;
    logic [15:0] ctrl;
    logic        last;
  } word_t;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RES} state_t;

  word_t           mem_q [FIFO_DEPTH];
  word_t           hold_q, head;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   count_q;
  state_t          state_q, state_d;
  logic            empty, full, push, pop, capture, abort;
  logic            res_valid_q, res_acc_q, res_to_q;
  logic [CNT_W-1:0] match_q;

  assign empty = (count_q == '0);
  assign full  = (count_q == LW'(FIFO_DEPTH));
  // When empty the outputs keep showing the last word that left the FIFO.
  assign head  = empty ? hold_q : mem_q[rd_ptr_q];
  assign push  = in_valid && !full;
  assign pop   = pmm_data_valid && pmm_ready_status;

  assign in_ready       = !full;
  assign pmm_data       = head.data;
  assign pmm_control    = head.ctrl;
  assign pmm_data_valid = (state_q == SEND) && !empty;
  assign busy           = (state_q != IDLE) || !empty;
  assign fifo_level     = count_q;
  assign res_valid      = res_valid_q;
  assign res_accepted   = res_acc_q;
  assign res_timeout    = res_to_q;
  assign match_count    = match_q;

`ifdef PMM_FEEDER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_q;
  logic           wd_run;

  // A ready in WAIT_RES ends the sequence normally, so it never counts toward the abort.
  assign wd_run = (pmm_data_valid && !pmm_ready_status) ||
                  (state_q == WAIT_RES && !pmm_ready_status);
  assign abort  = wd_run && (wd_q == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || pop || (state_d != state_q)) wd_q <= '0;
    else if (wd_run)                          wd_q <= wd_q + 1'b1;
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE:     if (!empty) state_d = SEND;
      SEND:     if (pop && head.last) state_d = WAIT_RES;
      WAIT_RES: if (pmm_ready_status) begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{data: in_data, ctrl: in_control, last: in_last};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (abort) begin
        // Drop everything queued, but keep a word the host is writing this same edge.
        rd_ptr_q <= wr_ptr_q;
        count_q  <= LW'(push);
      end else begin
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          hold_q   <= head;
        end
        count_q <= count_q + LW'(push) - LW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_acc_q   <= 1'b0;
      res_to_q    <= 1'b0;
      match_q     <= '0;
    end else begin
      res_valid_q <= capture || abort;
      if (capture) begin
        res_acc_q <= pmm_accepted_status;
        res_to_q  <= 1'b0;
        if (pmm_accepted_status && (match_q != '1)) match_q <= match_q + 1'b1;
      end else if (abort) begin
        res_acc_q <= 1'b0;
        res_to_q  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pmm_feeder.sv
// Scoreboard bench for pmm_feeder: stimulus queues expected words/results, a monitor checks them as they appear.
module tb_pmm_feeder;
`ifdef PMM_FEEDER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_last;
  logic [63:0] in_data, pmm_data;
  logic [15:0] in_control, pmm_control, match_count;
  logic        pmm_data_valid, pmm_ready_status, pmm_accepted_status;
  logic        res_valid, res_accepted, res_timeout, busy;
  logic [2:0]  fifo_level;

  pmm_feeder #(.FIFO_DEPTH(4), .CNT_W(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_control(in_control), .in_last(in_last),
    .pmm_data(pmm_data), .pmm_control(pmm_control), .pmm_data_valid(pmm_data_valid),
    .pmm_ready_status(pmm_ready_status), .pmm_accepted_status(pmm_accepted_status),
    .res_valid(res_valid), .res_accepted(res_accepted), .res_timeout(res_timeout),
    .match_count(match_count), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [63:0] d; logic [15:0] c; logic l; } wexp_t;
  typedef struct packed { logic acc; logic to; logic [15:0] mc; } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  chk_consec = 1'b0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: compare transfers and results against the queues; check stall stability.
  initial begin
    wexp_t e;
    rexp_t r;
    int    last_done_cyc = 0;
    int    last_xfer_cyc = 0;
    int    seq_pos = 0;
    logic  prev_stall = 1'b0;
    logic [79:0] prev_dc = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        seq_pos = 0;
      end else begin
        if (prev_stall && !(res_valid && res_timeout)) begin
          chk("stall_valid", 80'(pmm_data_valid), 80'(1));
          chk("stall_data", {pmm_data, pmm_control}, prev_dc);
        end
        if (pmm_data_valid && pmm_ready_status) begin
          if (wq.size() == 0) chk("xfer_unexpected", 80'(1), 80'(0));
          else begin
            e = wq.pop_front();
            chk("xfer_data", 80'(pmm_data), 80'(e.d));
            chk("xfer_ctrl", 80'(pmm_control), 80'(e.c));
            if (chk_consec && seq_pos > 0) chk("xfer_consec", 80'(cyc - last_xfer_cyc), 80'(1));
            last_xfer_cyc = cyc;
            if (e.l) begin
              last_done_cyc = cyc;
              seq_pos = 0;
            end else seq_pos++;
          end
        end
        if (res_valid) begin
          if (rq.size() == 0) chk("res_unexpected", 80'(1), 80'(0));
          else begin
            r = rq.pop_front();
            chk("res_accepted", 80'(res_accepted), 80'(r.acc));
            chk("res_timeout", 80'(res_timeout), 80'(r.to));
            chk("match_count", 80'(match_count), 80'(r.mc));
            if (!r.to) chk("wait_dwell", 80'(cyc - last_done_cyc >= 2), 80'(1));
          end
        end
        prev_stall = pmm_data_valid && !pmm_ready_status;
        prev_dc = {pmm_data, pmm_control};
      end
    end
  end

  task automatic push(input logic [63:0] d, input logic [15:0] c, input logic l, input logic stored);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_control = c; in_last = l;
    chk("push_in_ready", 80'(in_ready), 80'(stored));
    if (stored) wq.push_back('{d: d, c: c, l: l});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string nm);
    int k;
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (wq.size() == 0 && rq.size() == 0 && !busy && !res_valid) break;
    end
    chk(nm, 80'(k < 200), 80'(1));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"}, 80'(in_ready), 80'(1));
    chk({nm, "_valid"}, 80'(pmm_data_valid), 80'(0));
    chk({nm, "_data"}, {pmm_data, pmm_control}, 80'(0));
    chk({nm, "_res"}, 80'({res_valid, res_accepted, res_timeout}), 80'(0));
    chk({nm, "_match"}, 80'(match_count), 80'(0));
    chk({nm, "_busy"}, 80'(busy), 80'(0));
    chk({nm, "_level"}, 80'(fifo_level), 80'(0));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_control = '0; in_last = 1'b0;
    pmm_ready_status = 1'b0; pmm_accepted_status = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;

    // Single sequence, ready high, accepted
    pmm_ready_status = 1'b1; pmm_accepted_status = 1'b1; chk_consec = 1'b1;
    rq.push_back('{acc: 1'b1, to: 1'b0, mc: 16'd1});
    push(64'h11, 16'h0101, 1'b0, 1'b1);
    push(64'h22, 16'h0202, 1'b0, 1'b1);
    push(64'h33, 16'h0303, 1'b1, 1'b1);
    idle(1);
    wait_drain("seq1_drain");
    chk_consec = 1'b0;
    chk("seq1_match", 80'(match_count), 80'(1));

    // Backpressure: one transfer then five stalled cycles
    pmm_ready_status = 1'b0;
    rq.push_back('{acc: 1'b1, to: 1'b0, mc: 16'd2});
    push(64'hA1, 16'h1A1A, 1'b0, 1'b1);
    push(64'hA2, 16'h2A2A, 1'b0, 1'b1);
    push(64'hA3, 16'h3A3A, 1'b0, 1'b1);
    push(64'hA4, 16'h4A4A, 1'b1, 1'b1);
    idle(1);
    @(posedge clk); #1 pmm_ready_status = 1'b1;
    @(posedge clk); #1 pmm_ready_status = 1'b0;
    repeat (5) @(posedge clk);
    #1 pmm_ready_status = 1'b1;
    wait_drain("bp_drain");

    // Full FIFO: last two words must be refused
    pmm_ready_status = 1'b0; pmm_accepted_status = 1'b0;
    rq.push_back('{acc: 1'b0, to: 1'b0, mc: 16'd2});
    push(64'hB0, 16'h00B0, 1'b0, 1'b1);
    push(64'hB1, 16'h00B1, 1'b0, 1'b1);
    push(64'hB2, 16'h00B2, 1'b0, 1'b1);
    push(64'hB3, 16'h00B3, 1'b1, 1'b1);
    push(64'hB4, 16'h00B4, 1'b0, 1'b0);
    push(64'hB5, 16'h00B5, 1'b1, 1'b0);
    idle(1);
    chk("full_level", 80'(fifo_level), 80'(4));
    chk("full_in_ready", 80'(in_ready), 80'(0));
    @(posedge clk); #1 pmm_ready_status = 1'b1;
    @(posedge clk); #1;
    chk("full_pop_in_ready", 80'(in_ready), 80'(1));
    chk("full_pop_level", 80'(fifo_level), 80'(3));
    wait_drain("full_drain");

    // Reset with two words queued mid-sequence
    pmm_ready_status = 1'b0;
    push(64'hC0, 16'h00C0, 1'b0, 1'b1);
    push(64'hC1, 16'h00C1, 1'b0, 1'b1);
    idle(2);
    reset = 1'b1;
    wq.delete();
    @(posedge clk); #1;
    chk_reset_vals("midrst");
    reset = 1'b0;
    pmm_ready_status = 1'b1;
    idle(4);

    // Back-to-back sequences, accepted 0 then 1
    pmm_accepted_status = 1'b0;
    rq.push_back('{acc: 1'b0, to: 1'b0, mc: 16'd0});
    rq.push_back('{acc: 1'b1, to: 1'b0, mc: 16'd1});
    push(64'hD0, 16'h00D0, 1'b0, 1'b1);
    push(64'hD1, 16'h00D1, 1'b1, 1'b1);
    push(64'hE0, 16'h00E0, 1'b0, 1'b1);
    push(64'hE1, 16'h00E1, 1'b1, 1'b1);
    idle(1);
    begin
      int k;
      for (k = 0; k < 50 && rq.size() > 1; k++) @(posedge clk);
      chk("b2b_first_res", 80'(k < 50), 80'(1));
    end
    pmm_accepted_status = 1'b1;
    wait_drain("b2b_drain");
    chk("b2b_match", 80'(match_count), 80'(1));

`ifdef PMM_FEEDER_TIMEOUT_EN
    // Watchdog: ready stuck low
    pmm_ready_status = 1'b0;
    push(64'hF0, 16'h00F0, 1'b1, 1'b1);
    idle(1);
    begin
      int t0, k;
      for (k = 0; k < 10; k++) begin
        @(negedge clk);
        if (pmm_data_valid) break;
      end
      chk("to_valid_rise", 80'(k < 10), 80'(1));
      t0 = cyc;
      rq.push_back('{acc: 1'b0, to: 1'b1, mc: 16'd1});
      for (k = 0; k < 40; k++) begin
        @(negedge clk);
        if (res_valid) break;
      end
      chk("to_latency", 80'(cyc - t0), 80'(8));
      wq.delete();
      @(posedge clk); #1;
      chk("to_level", 80'(fifo_level), 80'(0));
      chk("to_busy", 80'(busy), 80'(0));
    end
    pmm_ready_status = 1'b1;
    idle(3);
`endif

    chk("end_queues", 80'(wq.size() + rq.size()), 80'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
